pio_host_bridge: RTL

//  Host-side front end for the PIO block. Converts a valid/ready register bus into the PIO's
//  one-cycle action/mindex/index/din strobes. Captures PIO read data (PULL, version) into a

---
 rtl/pio_pkg.sv | 47 ++++
 rtl/pio_bridge_decode.sv | 56 +++++
 rtl/pio_host_bridge.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/pio_pkg.sv
// Shared definitions for the PIO host bridge: action codes (same encoding as the PIO core),
// register offsets, bridge FSM states and the decoder result record.
package pio_pkg;

  typedef enum logic [3:0] {
    ActNone  = 4'd0,
    ActInstr = 4'd1,
    ActPend  = 4'd2,
    ActPull  = 4'd3,
    ActPush  = 4'd4,
    ActGrps  = 4'd5,
    ActEn    = 4'd6,
    ActDiv   = 4'd7,
    ActSides = 4'd8,
    ActImm   = 4'd9,
    ActShift = 4'd10
  } pio_action_e;

  localparam logic [5:0] OffPend    = 6'h20;
  localparam logic [5:0] OffPull    = 6'h21;
  localparam logic [5:0] OffPush    = 6'h22;
  localparam logic [5:0] OffGrps    = 6'h23;
  localparam logic [5:0] OffEn      = 6'h24;
  localparam logic [5:0] OffDiv     = 6'h25;
  localparam logic [5:0] OffImm     = 6'h26;
  localparam logic [5:0] OffShift   = 6'h27;
  localparam logic [5:0] OffVersion = 6'h28;
  localparam logic [5:0] OffStatus  = 6'h29;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StIssue,
    StCapture,
    StResp
  } bridge_state_e;

  typedef struct packed {
    pio_action_e action;
    logic        is_read;
    logic        needs_tx_space;
    logic        needs_rx_data;
    logic        is_status;
    logic        err;
  } bridge_decode_t;

endpackage

// File: rtl/pio_bridge_decode.sv
// Combinational register-offset decoder: maps a latched offset/direction to the PIO action
// and the checks the bridge FSM must apply before issuing it.
module pio_bridge_decode
  import pio_pkg::*;
(
  input  logic           we,
  input  logic [5:0]     offset,
  output bridge_decode_t dec
);

  pio_action_e act;
  logic        write_reg;
  logic        known;
  logic        status;

  always_comb begin
    act       = ActNone;
    write_reg = 1'b1;
    known     = 1'b1;
    status    = 1'b0;
    if (!offset[5]) begin
      act = ActInstr;
    end else begin
      case (offset)
        OffPend:    act = ActPend;
        OffPull: begin
          act       = ActPull;
          write_reg = 1'b0;
        end
        OffPush:    act = ActPush;
        OffGrps:    act = ActGrps;
        OffEn:      act = ActEn;
        OffDiv:     act = ActDiv;
        OffImm:     act = ActImm;
        OffShift:   act = ActShift;
        OffVersion: write_reg = 1'b0;
        OffStatus: begin
          write_reg = 1'b0;
          status    = 1'b1;
        end
        default:    known = 1'b0;
      endcase
    end

    dec     = '0;
    dec.err = !known || (we != write_reg);
    if (!dec.err) begin
      dec.action         = act;
      dec.is_read        = !write_reg && !status;
      dec.needs_tx_space = (act == ActPush);
      dec.needs_rx_data  = (act == ActPull);
      dec.is_status      = status;
    end
  end

endmodule

// File: rtl/pio_host_bridge.sv
// Valid/ready register bus to PIO action-strobe bridge with read-data response channel.
// Optional feature: define PIO_BRIDGE_BLOCKING_EN to wait (bounded) for FIFO space/data.
module pio_host_bridge
  import pio_pkg::*;
#(
  parameter int unsigned NUM_MACHINES   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_we,
  input  logic [7:0]              cmd_addr,
  input  logic [31:0]             cmd_wdata,
  output logic                    rsp_valid,
  output logic [31:0]             rsp_rdata,
  output logic                    rsp_err,
  output logic [3:0]              pio_action,
  output logic [1:0]              pio_mindex,
  output logic [4:0]              pio_index,
  output logic [31:0]             pio_din,
  input  logic [31:0]             pio_dout,
  input  logic [NUM_MACHINES-1:0] pio_tx_full,
  input  logic [NUM_MACHINES-1:0] pio_rx_empty
);

  if (NUM_MACHINES != 4 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("pio_host_bridge: NUM_MACHINES must be 4 and TIMEOUT_CYCLES >= 1");
  end

  bridge_state_e  state_q, state_d;
  logic           cmd_ready_q;
  logic           we_q;
  logic [7:0]     addr_q;
  logic [31:0]    wdata_q;
  bridge_decode_t dec;
  logic           accept;
  logic           fifo_ok;
  logic [1:0]     mach;

  logic           rsp_valid_q;
  logic [31:0]    rsp_rdata_q, rsp_rdata_d;
  logic           rsp_err_q, rsp_err_d;
  logic [3:0]     act_q, act_d;
  logic [1:0]     mindex_q, mindex_d;
  logic [4:0]     index_q, index_d;
  logic [31:0]    din_q, din_d;

`ifdef PIO_BRIDGE_BLOCKING_EN
  localparam logic [15:0] WaitLimit = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wait_q, wait_d;
`endif

  assign accept = cmd_valid && cmd_ready_q;
  assign mach   = addr_q[7:6];

  pio_bridge_decode u_decode (
    .we     (we_q),
    .offset (addr_q[5:0]),
    .dec    (dec)
  );

  // Only the addressed machine's flag matters, even if other flags toggle this cycle.
  assign fifo_ok = !(dec.needs_tx_space && pio_tx_full[mach]) &&
                   !(dec.needs_rx_data && pio_rx_empty[mach]);

  always_comb begin
    state_d     = state_q;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    act_d       = ActNone;
    mindex_d    = '0;
    index_d     = '0;
    din_d       = '0;
`ifdef PIO_BRIDGE_BLOCKING_EN
    wait_d      = wait_q;
`endif
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StCheck;
`ifdef PIO_BRIDGE_BLOCKING_EN
          wait_d  = '0;
`endif
        end
      end
      StCheck: begin
        if (dec.err || dec.is_status) begin
          state_d     = StResp;
          rsp_err_d   = dec.err;
          rsp_rdata_d = dec.is_status ? 32'({pio_rx_empty, pio_tx_full}) : '0;
        end else if (fifo_ok) begin
          state_d = StIssue;
        end else begin
`ifdef PIO_BRIDGE_BLOCKING_EN
          if (wait_q >= WaitLimit) begin
            state_d   = StResp;
            rsp_err_d = 1'b1;
          end else begin
            wait_d = wait_q + 16'd1;
          end
`else
          state_d   = StResp;
          rsp_err_d = 1'b1;
`endif
        end
      end
      StIssue:   state_d = StCapture;
      StCapture: begin
        // PIO drove dout at the end of ISSUE; VERSION reads see the idle dout value.
        state_d     = StResp;
        rsp_rdata_d = dec.is_read ? pio_dout : '0;
      end
      StResp:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase

    if (state_d == StIssue) begin
      act_d    = dec.action;
      mindex_d = (dec.action == ActInstr) ? 2'd0 : addr_q[7:6];
      index_d  = (dec.action == ActInstr) ? addr_q[4:0] : 5'd0;
      din_d    = we_q ? wdata_q : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cmd_ready_q <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      act_q       <= ActNone;
      mindex_q    <= '0;
      index_q     <= '0;
      din_q       <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= (state_d == StIdle);
      if (accept) begin
        we_q    <= cmd_we;
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
      end
      rsp_valid_q <= (state_d == StResp);
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      act_q       <= act_d;
      mindex_q    <= mindex_d;
      index_q     <= index_d;
      din_q       <= din_d;
    end
  end

`ifdef PIO_BRIDGE_BLOCKING_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end
`endif

  assign cmd_ready  = cmd_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_err    = rsp_err_q;
  assign pio_action = act_q;
  assign pio_mindex = mindex_q;
  assign pio_index  = index_q;
  assign pio_din    = din_q;

endmodule
